classificador_digito: RTL and testbench
=======================================

// Module: classificador_digito
// PURPOSE
//  Streaming nearest-template digit classifier for the HUD digit reader.
//  Accepts one ROWSxCOLS grayscale frame in raster order, one pixel per handshake.
//  Accumulates the squared pixel difference against N_TEMPL runtime-loadable
//  templates in parallel, then picks the closest template with a serial argmin.
//  Replaces the fixed per-digit combinational difference arrays with one block
//  whose width, size and template count are parameters.
// PARAMETERS
//  PIX_W    8        pixel / template sample width (unsigned)
//  ROWS     11       frame rows
//  COLS     11       frame columns
//  N_TEMPL  10       number of templates (digits 0..9)
//  THRESH   500000   max distance for res_ok=1
//  (local) NPIX=ROWS*COLS; AW=clog2(NPIX); TW=clog2(N_TEMPL); ACC_W=2*PIX_W+AW
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      asynchronous active-low reset
//  pix_valid  in   1      pix_data valid
//  pix_ready  out  1      block accepts a pixel this cycle
//  pix_data   in   PIX_W  pixel, raster order row 0 col 0 first
//  frame_clr  in   1      synchronous abort: discard partial frame/result
//  tmpl_we    in   1      template write strobe
//  tmpl_sel   in   TW     template index being written
//  tmpl_addr  in   AW     pixel index row*COLS+col
//  tmpl_data  in   PIX_W  template sample
//  res_valid  out  1      result available
//  res_ready  in   1      result consumed when res_valid&res_ready
//  res_idx    out  TW     index of closest template
//  res_dist   out  ACC_W  its sum of squared differences
//  res_ok     out  1      res_dist <= THRESH
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, pixel count 0, all accumulators 0,
//   template memory 0, pix_ready=0, res_valid=0, res_idx=0, res_dist=0, res_ok=0.
//  States: IDLE -> ACCUM -> COMPARE -> RESULT -> IDLE.
//  IDLE/ACCUM: pix_ready=1. Each pix_valid&pix_ready edge adds (|p-t_k[cnt]|)^2
//   to acc[k] for every k in parallel; cnt++. The first accept moves IDLE->ACCUM.
//   The accept with cnt==NPIX-1 moves the FSM to COMPARE with cnt=0.
//  Arithmetic: |p-t| is PIX_W bits unsigned, the square is 2*PIX_W bits, and acc is
//   ACC_W bits. Overflow is impossible by construction, so there is no saturation.
//  COMPARE: pix_ready=0. One template per cycle, k=0..N_TEMPL-1. Strict < update,
//   so ties resolve to the lowest index. After N_TEMPL edges -> RESULT.
//   res_valid rises exactly N_TEMPL edges after the last pixel is accepted.
//  RESULT: res_valid=1, pix_ready=0. res_idx/res_dist/res_ok stay stable until
//   res_valid&res_ready. That edge clears the accumulators, drops res_valid and
//   returns to IDLE. res_ready is ignored while res_valid=0.
//  frame_clr: in any state, on the next edge: acc=0, cnt=0, res_valid=0, -> IDLE.
//   It overrides a same-cycle pixel accept or result handshake. res_idx/res_dist
//   keep their last values.
//  tmpl_we: honoured only in IDLE with cnt==0 and frame_clr=0. It is ignored in all
//   other states. tmpl_sel>=N_TEMPL is ignored. tmpl_addr>=NPIX is ignored.
//   A write in the same cycle as the first pixel accept is also ignored.
//  Template memory: N_TEMPL x NPIX x PIX_W registers, with a read at index cnt.
// TESTING
//  T1 tmpl 3 all 100, others 0; frame all 100 -> res_idx=3, dist=0, ok=1,
//     res_valid exactly 10 edges after the last accept.
//  T2 tmpl 2 == tmpl 5 (all 40), others 0; frame all 40 -> res_idx=2, dist=0.
//  T3 N_TEMPL=1, tmpl 0 all 0; frame all 255 -> res_dist=7868025, res_ok=0,
//     no wrap.
//  T4 res_ready low 6 cycles in RESULT -> outputs stable, pix_ready=0;
//     pix_valid held high never accepted until the handshake.
//  T5 reset_n low after 60 pixels -> all outputs 0 immediately; the next 121-pixel
//     frame gives the correct result. A repeat with frame_clr gives the same result.
//  T6 tmpl_we during ACCUM (tmpl 0 addr 0 = 255) -> memory unchanged
//     (readback via a matching frame: dist unchanged).

Source files
------------

// File: rtl/classificador_digito_if.sv
// Pixel stream, template write port and result handshake of the digit classifier.
// The master side feeds pixels and templates; the slave side is the classifier.
interface classificador_digito_if #(
    parameter int PIX_W   = 8,
    parameter int ROWS    = 11,
    parameter int COLS    = 11,
    parameter int N_TEMPL = 10
);
    localparam int NPIX  = ROWS * COLS;
    localparam int AW    = $clog2(NPIX);
    localparam int TW    = (N_TEMPL > 1) ? $clog2(N_TEMPL) : 1;
    localparam int ACC_W = 2 * PIX_W + AW;

    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             frame_clr;
    logic             tmpl_we;
    logic [TW-1:0]    tmpl_sel;
    logic [AW-1:0]    tmpl_addr;
    logic [PIX_W-1:0] tmpl_data;
    logic             res_valid;
    logic             res_ready;
    logic [TW-1:0]    res_idx;
    logic [ACC_W-1:0] res_dist;
    logic             res_ok;

    modport master (
        output pix_valid, pix_data, frame_clr,
        output tmpl_we, tmpl_sel, tmpl_addr, tmpl_data,
        output res_ready,
        input  pix_ready, res_valid, res_idx, res_dist, res_ok
    );

    modport slave (
        input  pix_valid, pix_data, frame_clr,
        input  tmpl_we, tmpl_sel, tmpl_addr, tmpl_data,
        input  res_ready,
        output pix_ready, res_valid, res_idx, res_dist, res_ok
    );
endinterface

// File: rtl/classificador_digito.sv
// Streaming nearest-template digit classifier: parallel sum-of-squared-difference
// accumulation over one raster frame, followed by a serial argmin over the templates.
module classificador_digito #(
    parameter int          PIX_W   = 8,
    parameter int          ROWS    = 11,
    parameter int          COLS    = 11,
    parameter int          N_TEMPL = 10,
    parameter int unsigned THRESH  = 500000
) (
    input logic                   clk,
    input logic                   reset_n,
    classificador_digito_if.slave bus
);
    localparam int NPIX  = ROWS * COLS;
    localparam int AW    = $clog2(NPIX);
    localparam int TW    = (N_TEMPL > 1) ? $clog2(N_TEMPL) : 1;
    localparam int ACC_W = 2 * PIX_W + AW;

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, RESULT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_pix_ready;
    logic               w_res_valid;
    logic               w_rdy;
    logic               w_accept;
    logic               w_last_pix;
    logic               w_res_hs;
    logic               w_tmpl_wr;

    logic [AW-1:0]      r_cnt;
    logic [PIX_W-1:0]   r_tmpl [N_TEMPL][NPIX];
    logic [ACC_W-1:0]   r_acc  [N_TEMPL];
    logic [PIX_W-1:0]   w_diff [N_TEMPL];
    logic [2*PIX_W-1:0] w_sq   [N_TEMPL];

    logic [TW-1:0]      r_cmp_idx;
    logic [TW-1:0]      r_best_idx;
    logic [ACC_W-1:0]   r_best_dist;
    logic [ACC_W-1:0]   w_cand;
    logic               w_better;
    logic               w_cmp_last;
    logic [TW-1:0]      w_fin_idx;
    logic [ACC_W-1:0]   w_fin_dist;
    logic [TW-1:0]      r_res_idx;
    logic [ACC_W-1:0]   r_res_dist;
    logic               r_res_ok;

    // pix_ready must read 0 for the whole time reset is held, not just after the next edge.
    assign w_rdy      = w_pix_ready & reset_n;
    assign w_accept   = bus.pix_valid & w_rdy;
    assign w_last_pix = w_accept && (int'(r_cnt) == NPIX - 1);
    assign w_res_hs   = (r_state == RESULT) && bus.res_ready;
    assign w_cmp_last = int'(r_cmp_idx) == N_TEMPL - 1;

    assign w_tmpl_wr = bus.tmpl_we && (r_state == IDLE) && (r_cnt == '0) && !bus.frame_clr
                       && !w_accept && (int'(bus.tmpl_sel) < N_TEMPL)
                       && (int'(bus.tmpl_addr) < NPIX);

    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.frame_clr) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_accept) w_state_nxt = w_last_pix ? COMPARE : ACCUM;
                ACCUM:   if (w_last_pix) w_state_nxt = COMPARE;
                COMPARE: if (w_cmp_last) w_state_nxt = RESULT;
                RESULT:  if (bus.res_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_pix_ready = 1'b0;
        w_res_valid = 1'b0;
        unique case (r_state)
            IDLE, ACCUM: w_pix_ready = 1'b1;
            RESULT:      w_res_valid = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          r_cnt <= '0;
        else if (bus.frame_clr) r_cnt <= '0;
        else if (w_accept)     r_cnt <= w_last_pix ? '0 : r_cnt + AW'(1);
    end

    // NOTE: the template store is cleared by reset because a blank template set is a
    // defined, observable state; plain data memories would normally be left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TEMPL; k++)
                for (int i = 0; i < NPIX; i++)
                    r_tmpl[k][i] <= '0;
        end else if (w_tmpl_wr) begin
            r_tmpl[bus.tmpl_sel][bus.tmpl_addr] <= bus.tmpl_data;
        end
    end

    always_comb begin
        for (int k = 0; k < N_TEMPL; k++) begin
            w_diff[k] = (bus.pix_data >= r_tmpl[k][r_cnt]) ? bus.pix_data - r_tmpl[k][r_cnt]
                                                          : r_tmpl[k][r_cnt] - bus.pix_data;
            w_sq[k]   = (2*PIX_W)'(w_diff[k]) * (2*PIX_W)'(w_diff[k]);
        end
    end

    // ACC_W leaves room for NPIX full-scale squares, so the sum cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TEMPL; k++) r_acc[k] <= '0;
        end else if (bus.frame_clr || w_res_hs) begin
            for (int k = 0; k < N_TEMPL; k++) r_acc[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < N_TEMPL; k++) r_acc[k] <= r_acc[k] + ACC_W'(w_sq[k]);
        end
    end

    // Strict less-than keeps the lowest index on ties; template 0 seeds the search.
    assign w_cand     = r_acc[r_cmp_idx];
    assign w_better   = (r_cmp_idx == '0) || (w_cand < r_best_dist);
    assign w_fin_idx  = w_better ? r_cmp_idx : r_best_idx;
    assign w_fin_dist = w_better ? w_cand : r_best_dist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_idx   <= '0;
            r_best_idx  <= '0;
            r_best_dist <= '0;
            r_res_idx   <= '0;
            r_res_dist  <= '0;
            r_res_ok    <= 1'b0;
        end else if ((r_state == COMPARE) && !bus.frame_clr) begin
            r_cmp_idx   <= w_cmp_last ? '0 : r_cmp_idx + TW'(1);
            r_best_idx  <= w_fin_idx;
            r_best_dist <= w_fin_dist;
            if (w_cmp_last) begin
                r_res_idx  <= w_fin_idx;
                r_res_dist <= w_fin_dist;
                r_res_ok   <= {{(64-ACC_W){1'b0}}, w_fin_dist} <= 64'(THRESH);
            end
        end else begin
            r_cmp_idx <= '0;
        end
    end

    assign bus.pix_ready = w_rdy;
    assign bus.res_valid = w_res_valid;
    assign bus.res_idx   = r_res_idx;
    assign bus.res_dist  = r_res_dist;
    assign bus.res_ok    = r_res_ok;

endmodule

// File: tb/tb_classificador_digito.sv
// Self-checking bench for classificador_digito: directed and randomized frames scored
// against a sum-of-squares / argmin reference model held in plain arrays.
module tb_classificador_digito;
    localparam int NPIX   = 121;
    localparam int N_T    = 10;
    localparam int TW     = 4;
    localparam int AW     = 7;
    localparam int THRESH = 500000;

    logic clk;
    logic reset_n;

    classificador_digito_if #(.PIX_W(8), .ROWS(11), .COLS(11), .N_TEMPL(N_T)) bus ();
    classificador_digito_if #(.PIX_W(8), .ROWS(11), .COLS(11), .N_TEMPL(1))   bus1 ();

    classificador_digito #(
        .PIX_W(8), .ROWS(11), .COLS(11), .N_TEMPL(N_T), .THRESH(THRESH)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    classificador_digito #(
        .PIX_W(8), .ROWS(11), .COLS(11), .N_TEMPL(1), .THRESH(THRESH)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tm [N_T][NPIX];
    int fr [NPIX];
    int exp_idx;
    int exp_dist;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: distance is the plain sum of squared differences; first minimum wins.
    task automatic model();
        int d;
        exp_idx  = 0;
        exp_dist = 0;
        for (int k = 0; k < N_T; k++) begin
            d = 0;
            for (int i = 0; i < NPIX; i++) d += (fr[i] - tm[k][i]) * (fr[i] - tm[k][i]);
            if (k == 0 || d < exp_dist) begin
                exp_idx  = k;
                exp_dist = d;
            end
        end
    endtask

    task automatic write_tmpl(input int sel, input int addr, input int data);
        bus.tmpl_we   = 1'b1;
        bus.tmpl_sel  = TW'(sel);
        bus.tmpl_addr = AW'(addr);
        bus.tmpl_data = 8'(data);
        step();
        bus.tmpl_we   = 1'b0;
    endtask

    task automatic load_fill(input int sel, input int val);
        for (int i = 0; i < NPIX; i++) begin
            tm[sel][i] = val;
            write_tmpl(sel, i, val);
        end
    endtask

    task automatic load_random_set();
        for (int k = 0; k < N_T; k++)
            for (int i = 0; i < NPIX; i++) begin
                tm[k][i] = int'($urandom_range(255));
                write_tmpl(k, i, tm[k][i]);
            end
    endtask

    // Offers fr[first..first+count-1]; inject drives an illegal template write alongside
    // pixels 0 (first accept, still IDLE) and 5 (mid-ACCUM).
    task automatic send_pixels(input string tag, input int first, input int count,
                               input bit bubbles, input bit inject);
        int  i      = first;
        int  budget = 0;
        bit  acc;
        while (i < first + count && budget < 2000) begin
            bus.tmpl_we = 1'b0;
            if (bubbles && $urandom_range(3) == 0) begin
                bus.pix_valid = 1'b0;
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = 8'(fr[i]);
                if (inject && (i == 0 || i == 5)) begin
                    bus.tmpl_we   = 1'b1;
                    bus.tmpl_sel  = '0;
                    bus.tmpl_addr = AW'((i == 0) ? 0 : 10);
                    bus.tmpl_data = 8'd255;
                end
            end
            acc = bus.pix_valid && bus.pix_ready;
            step();
            if (acc) i++;
            budget++;
        end
        bus.pix_valid = 1'b0;
        bus.tmpl_we   = 1'b0;
        check({tag, "_accepted"}, 64'(i - first), 64'(count));
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (bus.res_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(N_T));
    endtask

    task automatic check_result(input string tag);
        model();
        check({tag, "_idx"},  64'(bus.res_idx),  64'(exp_idx));
        check({tag, "_dist"}, 64'(bus.res_dist), 64'(exp_dist));
        check({tag, "_ok"},   64'(bus.res_ok),   64'(exp_dist <= THRESH));
    endtask

    task automatic handshake(input string tag);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(bus.pix_ready), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pix_ready"}, 64'(bus.pix_ready), 64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res_idx"},   64'(bus.res_idx),   64'd0);
        check({tag, "_res_dist"},  64'(bus.res_dist),  64'd0);
        check({tag, "_res_ok"},    64'(bus.res_ok),    64'd0);
    endtask

    initial begin
        int n;
        int acc_cnt;
        int sq_sum;
        int save_idx;
        int save_dist;

        reset_n = 1'b0;
        {bus.pix_valid, bus.frame_clr, bus.tmpl_we, bus.res_ready} = '0;
        bus.pix_data = '0; bus.tmpl_sel = '0; bus.tmpl_addr = '0; bus.tmpl_data = '0;
        {bus1.pix_valid, bus1.frame_clr, bus1.tmpl_we, bus1.res_ready} = '0;
        bus1.pix_data = '0; bus1.tmpl_sel = '0; bus1.tmpl_addr = '0; bus1.tmpl_data = '0;
        for (int k = 0; k < N_T; k++)
            for (int i = 0; i < NPIX; i++) tm[k][i] = 0;

        #12;
        check_zero_outputs("reset");
        step();
        reset_n = 1'b1;
        step();
        check("post_reset_ready", 64'(bus.pix_ready), 64'd1);
        check("post_reset_valid", 64'(bus.res_valid), 64'd0);

        // Single all-zero template against a full-scale frame: largest possible distance.
        acc_cnt = 0;
        n       = 0;
        while (acc_cnt < NPIX && n < 500) begin
            bus1.pix_valid = 1'b1;
            bus1.pix_data  = 8'd255;
            if (bus1.pix_ready) acc_cnt++;
            step();
            n++;
        end
        bus1.pix_valid = 1'b0;
        check("t3_accepted", 64'(acc_cnt), 64'(NPIX));
        sq_sum = 0;
        for (int i = 0; i < NPIX; i++) sq_sum += 255 * 255;
        n = 0;
        while (bus1.res_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("t3_latency", 64'(n), 64'd1);
        check("t3_idx",  64'(bus1.res_idx),  64'd0);
        check("t3_dist", 64'(bus1.res_dist), 64'(sq_sum));
        check("t3_dist_const", 64'(bus1.res_dist), 64'd7868025);
        check("t3_ok",   64'(bus1.res_ok),   64'd0);
        bus1.res_ready = 1'b1;
        step();
        bus1.res_ready = 1'b0;
        check("t3_valid_drop", 64'(bus1.res_valid), 64'd0);

        // Exact match on template 3.
        load_fill(3, 100);
        for (int i = 0; i < NPIX; i++) fr[i] = 100;
        send_pixels("t1", 0, NPIX, 1'b0, 1'b0);
        wait_result("t1");
        check_result("t1");

        // Result held while the consumer stalls; offered pixels must not be taken.
        save_idx  = exp_idx;
        save_dist = exp_dist;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'd7;
        for (int c = 0; c < 6; c++) begin
            check("t4_valid", 64'(bus.res_valid), 64'd1);
            check("t4_ready", 64'(bus.pix_ready), 64'd0);
            check("t4_idx",   64'(bus.res_idx),   64'(save_idx));
            check("t4_dist",  64'(bus.res_dist),  64'(save_dist));
            step();
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        bus.pix_valid = 1'b0;
        check("t4_valid_drop", 64'(bus.res_valid), 64'd0);
        check("t4_ready_back", 64'(bus.pix_ready), 64'd1);

        // Tie between templates 2 and 5 resolves to the lower index.
        load_fill(3, 0);
        load_fill(2, 40);
        load_fill(5, 40);
        for (int i = 0; i < NPIX; i++) fr[i] = 40;
        send_pixels("t2", 0, NPIX, 1'b1, 1'b0);
        wait_result("t2");
        check_result("t2");
        handshake("t2");

        // Random template sets; noisy copies of one template, then a fully random frame.
        for (int r = 0; r < 4; r++) begin
            int j;
            int v;
            load_random_set();
            j = int'($urandom_range(N_T - 1));
            for (int i = 0; i < NPIX; i++) begin
                v = tm[j][i] + int'($urandom_range(8)) - 4;
                fr[i] = (v < 0) ? 0 : (v > 255) ? 255 : v;
                if (r == 3) fr[i] = int'($urandom_range(255));
            end
            send_pixels("rand", 0, NPIX, 1'b1, 1'b0);
            wait_result("rand");
            check_result("rand");
            handshake("rand");
        end

        // Illegal template writes: out-of-range address/select, during frame_clr,
        // on the first accept and during ACCUM. None may change the memory.
        load_fill(0, 50);
        write_tmpl(0, 127, 255);
        write_tmpl(12, 0, 255);
        bus.frame_clr = 1'b1;
        write_tmpl(0, 1, 255);
        bus.frame_clr = 1'b0;
        for (int i = 0; i < NPIX; i++) fr[i] = 50;
        send_pixels("t6", 0, NPIX, 1'b0, 1'b1);
        wait_result("t6");
        check_result("t6");

        // frame_clr beats a same-cycle result handshake and keeps the last result.
        bus.frame_clr = 1'b1;
        bus.res_ready = 1'b1;
        step();
        bus.frame_clr = 1'b0;
        bus.res_ready = 1'b0;
        check("clr_valid", 64'(bus.res_valid), 64'd0);
        check("clr_idx",   64'(bus.res_idx),   64'(exp_idx));
        check("clr_dist",  64'(bus.res_dist),  64'(exp_dist));
        check("clr_ready", 64'(bus.pix_ready), 64'd1);

        // Asynchronous reset in the middle of a frame.
        load_random_set();
        for (int i = 0; i < NPIX; i++) fr[i] = int'($urandom_range(255));
        send_pixels("t5_part", 0, 60, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("t5_reset");
        for (int k = 0; k < N_T; k++)
            for (int i = 0; i < NPIX; i++) tm[k][i] = 0;
        step();
        reset_n = 1'b1;
        step();
        load_random_set();
        send_pixels("t5", 0, NPIX, 1'b1, 1'b0);
        wait_result("t5");
        check_result("t5");
        handshake("t5");

        // Same frame again after a frame_clr abort; the pixel offered with the clear is dropped.
        send_pixels("t5c_part", 0, 60, 1'b0, 1'b0);
        bus.frame_clr = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'd200;
        step();
        bus.frame_clr = 1'b0;
        bus.pix_valid = 1'b0;
        send_pixels("t5c", 0, NPIX, 1'b1, 1'b0);
        wait_result("t5c");
        check_result("t5c");
        handshake("t5c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
